decode_window_sequencer: RTL and testbench
==========================================

# decode_window_sequencer

Byte-stream buffer and sequencer that feeds the combinational decode stage. It accepts fixed-width fetch words, holds them in a byte-aligned shift buffer, and presents an 88-bit unescaped-instruction window (byte 0 at bits [7:0]) to decode. When decode reports the consumed instruction length, the buffer advances by that many bytes. It sits between the trace/fetch source and the decode modules.

## Interface

**Parameters**

- `BUF_BYTES`, 16: buffer capacity in bytes.
- `FETCH_BYTES`, 4: bytes per fetch word.
- `WINDOW_BYTES`, 11: decode window width in bytes (88 bits).
- Only the default combination is required to be supported.

**Ports**

- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `fetch_valid` input 1: a fetch word is offered.
- `fetch_data` input 32: fetch word; byte 0 at [7:0] is the earliest in the stream.
- `fetch_last` input 1: qualifies `fetch_valid`; this word ends the stream.
- `fetch_ready` output 1: the buffer accepts the word this cycle.
- `flush` input 1: discard all buffered bytes and the drain state.
- `window` output 88: buffered bytes [0..10]; bytes at or above `level` read as 0.
- `window_valid` output 1: the window may be decoded.
- `consume` input 1: decode retires an instruction this cycle.
- `consume_len` input 4: instruction length in bytes, valid 1..11.
- `level` output 5: number of buffered bytes, 0..16.
- `err` output 1: sticky protocol error.

## Operation

**State**

- `buf[16 bytes]`
- `count[4:0]`
- `drain` flag
- `err` flag

**Combinational outputs** (all from registers only; no input-to-output combinational path)

- `fetch_ready = ~drain & (count <= BUF_BYTES-FETCH_BYTES)`
- `window_valid = (count >= 11) | (drain & count != 0)`
- `window` byte i = `buf[i]` if i < `count`, else 8'h00.
- `level = count`

**Events**

- Fetch accepted: `fetch_valid & fetch_ready`.
- Consume legal: `consume & window_valid & consume_len >= 1 & consume_len <= 11 & consume_len <= count`.
- Illegal consume: `consume` asserted and the consume-legal condition is false. Sets `err` and is otherwise ignored (no shift). `err` clears only on `reset`; `flush` does not clear it.

**Next state, in priority order**

1. `reset`: `buf` = 0, `count` = 0, `drain` = 0, `err` = 0.
2. `flush`:
   - `count` = 0 and `drain` = 0; `buf` contents are don't-care but outputs still mask them.
   - Any fetch accepted in the same cycle is dropped (`fetch_ready` may still be 1).
   - Consume in the same cycle is ignored and does not set `err`.
3. Otherwise, let `L` = `consume_len` if the consume is legal, else 0:
   - Shift `buf` down by `L` bytes.
   - If a fetch is accepted, write its 4 bytes at positions `count-L .. count-L+3`.
   - `count' = count - L + (fetch accepted ? 4 : 0)`.
   - An accepted `fetch_last` sets `drain`.
   - `drain` clears when `count'` == 0.
   - Simultaneous fetch and consume is always legal. Capacity holds because acceptance requires `count <= 12`.

**Arithmetic**

- `count` is 5 bits and never exceeds 16 or underflows. Both properties are bench assertions.
- Shift and insert are byte-granular muxes; there is no wrap-around (linear buffer, not circular).

## Timing

- Reset values:
  - `fetch_ready` = 1
  - `window_valid` = 0
  - `window` = 0
  - `level` = 0
  - `err` = 0
- Fetch-to-window latency: 1 cycle. A word accepted at edge N is visible in `window` and `level` after edge N.
- Consume takes effect at the next edge. The new window appears 1 cycle after `consume`.
- Sustained throughput: one consume per cycle while `count >= 11`. With average instruction length at or below 4 and continuous fetch, the window never starves.
- `fetch_ready` depends only on `count` and `drain`. It does not rise in the same cycle as a consume; it reflects the post-consume count one cycle later.
- `reset` mid-operation discards the buffer on the same edge. `flush` mid-drain clears `drain`, so fetch resumes the next cycle.

## Test plan

- **Reset and fill:** reset, then 3 fetch words 0x03020100, 0x07060504, 0x0B0A0908 back-to-back.
  - After the third: `level` = 12, `window_valid` = 1, `window[87:0]` = bytes 0x00..0x0A.
- **Consume with concurrent fetch:** at `level` = 12, consume 3 together with fetch 0x0F0E0D0C.
  - Next cycle: `level` = 13, `window` byte0 = 0x03, byte8 = 0x0B.
- **Backpressure:** fill to 16 with no consume.
  - `fetch_ready` = 0 at `level` = 16 and also at `level` = 13.
  - Consume 4 from 16: `fetch_ready` = 1 one cycle later.
- **Drain:** fetch 0x44332211 with `fetch_last` from empty.
  - `window_valid` = 1, `level` = 4, `fetch_ready` = 0.
  - Consume 4: `level` = 0, `window_valid` = 0, `drain` cleared, `fetch_ready` = 1.
- **Illegal consume:** `level` = 4, not draining, consume 2.
  - `err` = 1 and `level` stays 4.
  - `consume_len` = 0 or 12 on a valid window also sets `err`.
  - `flush` leaves `err` = 1.
- **Flush priority:** at `level` = 8, assert `flush` + fetch + consume 2 in the same cycle.
  - Next cycle: `level` = 0, `window` = 0, `err` unchanged.
  - Mid-stream `reset` gives all outputs their reset values one edge later.

Source files
------------

// File: rtl/decode_window_sequencer.sv
// decode_window_sequencer: byte-aligned fetch buffer presenting an 11-byte decode window.
//   in : clk, reset, fetch_valid/fetch_data/fetch_last, flush, consume/consume_len
//   out: fetch_ready, window (byte 0 at [7:0]), window_valid, level (buffered bytes), err (sticky)
module decode_window_sequencer #(
  parameter int BUF_BYTES    = 16,
  parameter int FETCH_BYTES  = 4,
  parameter int WINDOW_BYTES = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_valid,
  input  logic [8*FETCH_BYTES-1:0]  fetch_data,
  input  logic                      fetch_last,
  output logic                      fetch_ready,
  input  logic                      flush,
  output logic [8*WINDOW_BYTES-1:0] window,
  output logic                      window_valid,
  input  logic                      consume,
  input  logic [3:0]                consume_len,
  output logic [4:0]                level,
  output logic                      err
);
  logic [7:0] buf_q [BUF_BYTES];
  logic [7:0] buf_d [BUF_BYTES];
  logic [4:0] count_q, count_d, shift, base;
  logic       drain_q, drain_d, err_q, err_d, accept, legal;
  always_comb begin
    fetch_ready  = ~drain_q & (count_q <= 5'(BUF_BYTES - FETCH_BYTES));
    window_valid = (count_q >= 5'(WINDOW_BYTES)) | (drain_q & (count_q != 5'd0));
    level        = count_q;
    err          = err_q;
  end
  always_comb begin
    window = '0;
    for (int i = 0; i < WINDOW_BYTES; i++)
      window[8*i +: 8] = (5'(i) < count_q) ? buf_q[i] : 8'h00;
  end
  // Consumed bytes shift out first; the fetch word lands just above the survivors.
  always_comb begin
    accept  = fetch_valid & fetch_ready;
    legal   = consume & window_valid & (consume_len != 4'd0) &
              (consume_len <= 4'(WINDOW_BYTES)) & ({1'b0, consume_len} <= count_q);
    shift   = legal ? {1'b0, consume_len} : 5'd0;
    base    = count_q - shift;
    for (int i = 0; i < BUF_BYTES; i++)
      buf_d[i] = (accept && (5'(i) - base) < 5'(FETCH_BYTES)) ?
                   fetch_data[{2'(i) - base[1:0], 3'b000} +: 8] :
                 ((5'(i) + shift) < 5'(BUF_BYTES)) ? buf_q[4'(i) + shift[3:0]] : 8'h00;
    count_d = flush ? 5'd0 : base + (accept ? 5'(FETCH_BYTES) : 5'd0);
    drain_d = ~flush & (drain_q | (accept & fetch_last)) & (count_d != 5'd0);
    err_d   = err_q | (consume & ~legal & ~flush);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '{default: 8'h00};
      count_q <= 5'd0;
      drain_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_decode_window_sequencer.sv
// tb_decode_window_sequencer: table-driven directed checks of the decode window sequencer.
module tb_decode_window_sequencer;
  logic        clk = 0, reset = 1, fetch_valid = 0, fetch_last = 0, flush = 0, consume = 0;
  logic [31:0] fetch_data = '0;
  logic [3:0]  consume_len = '0;
  logic        fetch_ready, window_valid, err;
  logic [87:0] window;
  logic [4:0]  level;
  int          checks = 0, errors = 0;
  decode_window_sequencer dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .fetch_last(fetch_last), .fetch_ready(fetch_ready), .flush(flush), .window(window),
    .window_valid(window_valid), .consume(consume), .consume_len(consume_len),
    .level(level), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        rst, fv;
    logic [31:0] fd;
    logic        fl, fls, cn;
    logic [3:0]  cl;
    logic [4:0]  lvl;
    logic        wv, fr, er;
    logic [87:0] win;
  } vec_t;
  vec_t vecs[$];
  function automatic vec_t mk(logic rst, logic fv, logic [31:0] fd, logic fl, logic fls,
                              logic cn, logic [3:0] cl, logic [4:0] lvl, logic wv,
                              logic fr, logic er, logic [87:0] win);
    vec_t v;
    v.rst = rst; v.fv = fv; v.fd = fd; v.fl = fl; v.fls = fls; v.cn = cn; v.cl = cl;
    v.lvl = lvl; v.wv = wv; v.fr = fr; v.er = er; v.win = win;
    return v;
  endfunction
  task automatic chk(string name, int idx, logic [87:0] got, logic [87:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask
  task automatic apply(int idx, vec_t v);
    @(negedge clk);
    reset = v.rst; fetch_valid = v.fv; fetch_data = v.fd; fetch_last = v.fl;
    flush = v.fls; consume = v.cn; consume_len = v.cl;
    @(posedge clk);
    #1;
    chk("level", idx, 88'(level), 88'(v.lvl));
    chk("window_valid", idx, 88'(window_valid), 88'(v.wv));
    chk("fetch_ready", idx, 88'(fetch_ready), 88'(v.fr));
    chk("err", idx, 88'(err), 88'(v.er));
    chk("window", idx, window, v.win);
  endtask
  always @(negedge clk) if (!reset && level > 5'd16) begin
    errors++;
    $display("FAIL level_range: got %0d expected at most 16", level);
  end
  initial begin
    vecs.push_back(mk(1,0,32'h0,0,0,0,0,  0,0,1,0, 88'h0));
    vecs.push_back(mk(0,1,32'h03020100,0,0,0,0,  4,0,1,0, 88'h03020100));
    vecs.push_back(mk(0,1,32'h07060504,0,0,0,0,  8,0,1,0, 88'h0706050403020100));
    vecs.push_back(mk(0,1,32'h0B0A0908,0,0,0,0, 12,1,1,0, 88'h0A09080706050403020100));
    vecs.push_back(mk(0,1,32'h0F0E0D0C,0,0,1,3, 13,1,0,0, 88'h0D0C0B0A090807060504_03));
    vecs.push_back(mk(0,1,32'hFFFFFFFF,0,0,0,0, 13,1,0,0, 88'h0D0C0B0A09080706050403));
    vecs.push_back(mk(0,0,32'h0,0,0,1,1,        12,1,1,0, 88'h0E0D0C0B0A090807060504));
    vecs.push_back(mk(0,1,32'h13121110,0,0,0,0, 16,1,0,0, 88'h0E0D0C0B0A090807060504));
    vecs.push_back(mk(0,0,32'h0,0,0,1,4,        12,1,1,0, 88'h1211100F0E0D0C0B0A0908));
    vecs.push_back(mk(0,0,32'h0,0,1,0,0,         0,0,1,0, 88'h0));
    vecs.push_back(mk(0,1,32'h44332211,1,0,0,0,  4,1,0,0, 88'h44332211));
    vecs.push_back(mk(0,1,32'hAABBCCDD,0,0,0,0,  4,1,0,0, 88'h44332211));
    vecs.push_back(mk(0,0,32'h0,0,0,1,4,         0,0,1,0, 88'h0));
    vecs.push_back(mk(0,1,32'h44332211,0,0,0,0,  4,0,1,0, 88'h44332211));
    vecs.push_back(mk(0,0,32'h0,0,0,1,2,         4,0,1,1, 88'h44332211));
    vecs.push_back(mk(0,0,32'h0,0,1,0,0,         0,0,1,1, 88'h0));
    vecs.push_back(mk(1,0,32'h0,0,0,0,0,         0,0,1,0, 88'h0));
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(0,1,32'h44332211,0,0,0,0,  4,0,1,0, 88'h44332211));
      vecs.push_back(mk(0,1,32'h88776655,0,0,0,0,  8,0,1,0, 88'h8877665544332211));
      vecs.push_back(mk(0,1,32'hCCBBAA99,0,0,0,0, 12,1,1,0, 88'hBBAA998877665544332211));
      vecs.push_back(mk(0,0,32'h0,0,0,1,4'(r*12), 12,1,1,1, 88'hBBAA998877665544332211));
      vecs.push_back(mk(1,0,32'h0,0,0,0,0,         0,0,1,0, 88'h0));
    end
    vecs.push_back(mk(0,1,32'h44332211,0,0,0,0,  4,0,1,0, 88'h44332211));
    vecs.push_back(mk(0,1,32'h88776655,0,0,0,0,  8,0,1,0, 88'h8877665544332211));
    vecs.push_back(mk(0,1,32'hDEADBEEF,0,1,1,2,  0,0,1,0, 88'h0));
    vecs.push_back(mk(0,1,32'h03020100,0,0,0,0,  4,0,1,0, 88'h03020100));
    vecs.push_back(mk(1,1,32'h07060504,0,0,0,0,  0,0,1,0, 88'h0));
    vecs.push_back(mk(0,1,32'h44332211,1,0,0,0,  4,1,0,0, 88'h44332211));
    vecs.push_back(mk(0,0,32'h0,0,1,0,0,         0,0,1,0, 88'h0));
    vecs.push_back(mk(0,1,32'h03020100,0,0,0,0,  4,0,1,0, 88'h03020100));
    repeat (2) @(posedge clk);
    foreach (vecs[i]) apply(i, vecs[i]);
    // Full-window consume leaves a single non-draining byte, which is not decodable.
    apply(100, mk(1,0,32'h0,0,0,0,0,          0,0,1,0, 88'h0));
    apply(101, mk(0,1,32'h03020100,0,0,0,0,   4,0,1,0, 88'h03020100));
    apply(102, mk(0,1,32'h07060504,0,0,0,0,   8,0,1,0, 88'h0706050403020100));
    apply(103, mk(0,1,32'h0B0A0908,0,0,0,0,  12,1,1,0, 88'h0A09080706050403020100));
    apply(104, mk(0,0,32'h0,0,0,1,11,         1,0,1,0, 88'h0B));
    apply(105, mk(0,0,32'h0,0,0,1,1,          1,0,1,1, 88'h0B));
    apply(106, mk(0,1,32'h0F0E0D0C,1,0,0,0,   5,1,0,1, 88'h0F0E0D0C0B));
    apply(107, mk(0,0,32'h0,0,0,1,2,          3,1,0,1, 88'h0F0E0D));
    apply(108, mk(0,0,32'h0,0,0,1,3,          0,0,1,1, 88'h0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
